seq_chunk_adder: RTL and testbench

- Multi-cycle, parametrised integer adder/subtractor for the datapath/ALU area.
- Adds two WIDTH-bit operands CHUNK bits per clock with ripple carry between chunks.
- Uses a valid/ready handshake on both input and output.
- Produces sum, carry-out, signed overflow and zero flags.
- Successor to the combinational single-bit adder cells: wide operands, carry-in, subtract mode and back-pressure.

---
 rtl/seq_chunk_adder.sv | 124 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle with ripple carry, valid/ready on both sides.
// Latency NCHUNK cycles from accept to o_valid; upstream is held off (o_ready=0) until the result is taken.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data_a,
   input  logic [WIDTH-1:0] i_data_b,
   input  logic             i_carry,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_carry,
   output logic             o_overflow,
   output logic             o_zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  opa_q, opa_d;
   logic [WIDTH-1:0]  opb_q, opb_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              cry_q, cry_d;
   logic              carry_q, carry_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   int                base;
   logic [CHUNK-1:0]  sa, sb;
   logic [CHUNK:0]    slice;
   logic              msb_cin;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         cry_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         cry_q   <= cry_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      cry_d   = cry_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      base    = int'(cnt_q) * CHUNK;
      sa      = opa_q[base +: CHUNK];
      sb      = opb_q[base +: CHUNK];
      slice   = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, cry_q};
      // Carry into the MSB recovered from the MSB's own sum bit.
      msb_cin = sa[CHUNK-1] ^ sb[CHUNK-1] ^ slice[CHUNK-1];

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               opa_d   = i_data_a;
               opb_d   = i_data_b ^ {WIDTH{i_sub}};
               cry_d   = i_carry ^ i_sub;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            res_d[base +: CHUNK] = slice[CHUNK-1:0];
            cry_d = slice[CHUNK];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NCHUNK - 1)) begin
               state_d = DONE;
               carry_d = slice[CHUNK];
               ovf_d   = msb_cin ^ slice[CHUNK];
               zero_d  = (res_d == '0);
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_ready    = (state_q == IDLE);
   assign o_valid    = (state_q == DONE);
   assign o_data     = res_q;
   assign o_carry    = carry_q;
   assign o_overflow = ovf_q;
   assign o_zero     = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench: 32/8 vector table, back-pressure and async-reset sequences, exhaustive 4/1 sweep.
module tb_seq_chunk_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_vld, in_rdy, out_vld, out_rdy;
   logic [31:0] a, b, dat;
   logic        cin, sub, c_o, v_o, z_o;

   logic        s_in_vld, s_in_rdy, s_out_vld, s_out_rdy;
   logic [3:0]  s_a, s_b, s_dat;
   logic        s_cin, s_sub, s_c, s_v, s_z;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(in_vld), .o_ready(in_rdy),
      .i_data_a(a), .i_data_b(b), .i_carry(cin), .i_sub(sub),
      .o_valid(out_vld), .i_ready(out_rdy), .o_data(dat),
      .o_carry(c_o), .o_overflow(v_o), .o_zero(z_o)
   );

   seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut_s (
      .i_clk(clk), .i_rst(rst), .i_valid(s_in_vld), .o_ready(s_in_rdy),
      .i_data_a(s_a), .i_data_b(s_b), .i_carry(s_cin), .i_sub(s_sub),
      .o_valid(s_out_vld), .i_ready(s_out_rdy), .o_data(s_dat),
      .o_carry(s_c), .o_overflow(s_v), .o_zero(s_z)
   );

   typedef struct {
      string       name;
      logic [31:0] a, b;
      logic        cin, sub;
      logic [31:0] exp_d;
      logic        exp_c, exp_v, exp_z;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Accept one op on the 32-bit DUT and wait for o_valid; leaves it in DONE with i_ready low.
   task automatic start_op(input string nm, input logic [31:0] oa, input logic [31:0] ob,
                           input logic oc, input logic os);
      int lat;
      for (int i = 0; i < 20 && !in_rdy; i++) begin
         @(posedge clk); #1;
      end
      chk({nm, " ready"}, 32'(in_rdy), 32'd1);
      in_vld = 1'b1; a = oa; b = ob; cin = oc; sub = os;
      @(posedge clk); #1;
      in_vld = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      lat = 20;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_vld) begin
            lat = i;
            break;
         end
      end
      chk({nm, " latency"}, 32'(lat), 32'd4);
   endtask

   task automatic release_out(input string nm);
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
      chk({nm, " valid drop"}, 32'(out_vld), 32'd0);
      chk({nm, " ready back"}, 32'(in_rdy), 32'd1);
   endtask

   vec_t vecs[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int sa_i, sb_i, full, sr;
      logic [3:0] ed;
      logic ec, ev;
      int lat;
      logic saw_vld;

      vecs[0] = '{"zero_add",  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{"wrap_add",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"ovf_add",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{"sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{"sub_7_5",   32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{"sub_7_5_b", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{"add_cin",   32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{"sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{"neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
      vecs[9] = '{"ripple",    32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};

      in_vld = 0; out_rdy = 0; a = 0; b = 0; cin = 0; sub = 0;
      s_in_vld = 0; s_out_rdy = 1; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0;

      #1;
      chk("rst valid",    32'(out_vld), 32'd0);
      chk("rst ready",    32'(in_rdy),  32'd1);
      chk("rst data",     dat,          32'd0);
      chk("rst carry",    32'(c_o),     32'd0);
      chk("rst overflow", 32'(v_o),     32'd0);
      chk("rst zero",     32'(z_o),     32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i]) begin
         start_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         chk({vecs[i].name, " data"},     dat,        vecs[i].exp_d);
         chk({vecs[i].name, " carry"},    32'(c_o),   32'(vecs[i].exp_c));
         chk({vecs[i].name, " overflow"}, 32'(v_o),   32'(vecs[i].exp_v));
         chk({vecs[i].name, " zero"},     32'(z_o),   32'(vecs[i].exp_z));
         release_out(vecs[i].name);
      end

      // Back-pressure: result must hold and requests must be ignored.
      start_op("bp", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_vld = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
         chk("bp valid held", 32'(out_vld), 32'd1);
         chk("bp ready low",  32'(in_rdy),  32'd0);
         chk("bp data held",  dat,          32'h8000_0000);
         chk("bp flags held", {29'd0, c_o, v_o, z_o}, 32'b010);
      end
      in_vld = 1'b0;
      release_out("bp");
      chk("bp data kept", dat, 32'h8000_0000);
      @(posedge clk); #1;
      chk("bp no accept", 32'(in_rdy), 32'd1);

      // Asynchronous reset two CALC edges into an operation.
      start_op("pre", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
      release_out("pre");
      in_vld = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; cin = 0; sub = 0;
      @(posedge clk); #1;
      in_vld = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst data",  dat,                       32'd0);
      chk("arst valid", 32'(out_vld),              32'd0);
      chk("arst ready", 32'(in_rdy),               32'd1);
      chk("arst flags", {29'd0, c_o, v_o, z_o},    32'd0);
      #2 rst = 1'b0;
      saw_vld = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_vld) saw_vld = 1'b1;
      end
      chk("arst no valid", 32'(saw_vld), 32'd0);
      start_op("post", 32'd3, 32'd4, 1'b0, 1'b0);
      chk("post data", dat, 32'd7);
      release_out("post");

      // Exhaustive 4-bit, 1-bit-chunk sweep against a signed/unsigned arithmetic model.
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               for (int is = 0; is < 2; is++) begin
                  sa_i = (ia >= 8) ? ia - 16 : ia;
                  sb_i = (ib >= 8) ? ib - 16 : ib;
                  if (is == 0) begin
                     full = ia + ib + ic;
                     ec   = (full > 15);
                     sr   = sa_i + sb_i + ic;
                  end else begin
                     full = ia - ib - ic;
                     ec   = (full >= 0);
                     sr   = sa_i - sb_i - ic;
                  end
                  ed = 4'(full & 15);
                  ev = (sr > 7) || (sr < -8);
                  for (int i = 0; i < 20 && !s_in_rdy; i++) begin
                     @(posedge clk); #1;
                  end
                  s_in_vld = 1'b1; s_a = 4'(ia); s_b = 4'(ib); s_cin = 1'(ic); s_sub = 1'(is);
                  @(posedge clk); #1;
                  s_in_vld = 1'b0; s_a = 4'($urandom); s_b = 4'($urandom);
                  lat = 20;
                  for (int i = 1; i <= 20; i++) begin
                     @(posedge clk); #1;
                     if (s_out_vld) begin
                        lat = i;
                        break;
                     end
                  end
                  chk("w4 latency",  32'(lat),  32'd4);
                  chk("w4 data",     32'(s_dat), 32'(ed));
                  chk("w4 carry",    32'(s_c),   32'(ec));
                  chk("w4 overflow", 32'(s_v),   32'(ev));
                  chk("w4 zero",     32'(s_z),   32'(ed == 4'd0));
                  @(posedge clk); #1;
               end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
